// File: rtl/cla_pkg.sv
// Shared definitions for the multi-word CLA sequencer.
//   CHUNK_W         : width of one adder chunk.
//   cla_seq_state_t : sequencer FSM state encoding.
package cla_pkg;

  localparam int CHUNK_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_t;

endpackage

// File: rtl/cla_5bit.sv
// 5-bit carry lookahead adder chunk.
//   a, b : 5-bit addends
//   cin  : carry in
//   sum  : 5-bit sum
//   cout : carry out of bit 4
module cla_5bit
  import cla_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  logic [CHUNK_W-1:0] g, p;
  logic [CHUNK_W:0]   c;
  logic               prod;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products over the generate/propagate terms,
  // so no carry depends on a lower carry (no ripple chain).
  // Term j=0 is cin; term j>0 is g[j-1]; each is qualified by the propagates
  // between its source bit and bit i.
  always_comb begin
    c    = '0;
    prod = 1'b0;
    c[0] = cin;
    for (int i = 1; i <= CHUNK_W; i++) begin
      for (int j = 0; j <= i; j++) begin
        if (j < i) begin
          prod = (j == 0) ? cin : g[j-1];
          for (int k = j; k < i; k++) begin
            prod = prod & p[k];
          end
          c[i] = c[i] | prod;
        end
      end
      c[i] = c[i] | g[i-1];
    end
  end

  assign sum  = p ^ c[CHUNK_W-1:0];
  assign cout = c[CHUNK_W];

endmodule

// File: rtl/cla_multiword_seq.sv
// Multi-word adder built around one shared 5-bit CLA; one chunk per cycle,
// LSB chunk first, carry chained through a register.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready : result handshake (out_sum, out_cout)
//   busy                : operation in progress or result pending
module cla_multiword_seq
  import cla_pkg::*;
#(
  parameter int NCHUNK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHUNK_W*NCHUNK-1:0] in_a,
  input  logic [CHUNK_W*NCHUNK-1:0] in_b,
  input  logic                      in_cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHUNK_W*NCHUNK-1:0] out_sum,
  output logic                      out_cout,
  output logic                      busy
);

  localparam int W  = CHUNK_W * NCHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  cla_seq_state_t     state, state_nxt;
  logic [W-1:0]       a_sh, b_sh, res_nxt;
  logic               carry;
  logic [CW-1:0]      cnt;
  logic [CHUNK_W-1:0] sum5;
  logic               cout5;
  logic               last;

  cla_5bit u_cla (
    .a    (a_sh[CHUNK_W-1:0]),
    .b    (b_sh[CHUNK_W-1:0]),
    .cin  (carry),
    .sum  (sum5),
    .cout (cout5)
  );

  // New chunk enters at the top; after NCHUNK steps chunk 0 sits at the bottom.
  generate
    if (NCHUNK == 1) begin : g_one
      assign res_nxt = sum5;
    end else begin : g_multi
      assign res_nxt = {sum5, out_sum[W-1:CHUNK_W]};
    end
  endgenerate

  assign last     = (cnt == CW'(NCHUNK - 1));
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> CHUNK_W;
          b_sh    <= b_sh >> CHUNK_W;
          out_sum <= res_nxt;
          carry   <= cout5;
          cnt     <= cnt + CW'(1);
          if (last) begin
            out_valid <= 1'b1;
            out_cout  <= cout5;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Self-checking bench for cla_multiword_seq (NCHUNK=4, W=20).
module tb_cla_multiword_seq;

  localparam int NCHUNK = 4;
  localparam int W      = 5 * NCHUNK;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_cin;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         out_valid, out_ready, out_cout, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_multiword_seq #(.NCHUNK(NCHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    int           hold;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation end to end; exp_* come from the caller.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [W-1:0] exp_sum, input logic exp_cout,
                       input int hold, input logic early_ready);
    int n;
    int lat;
    logic [W-1:0] held;
    in_a = a; in_b = b; in_cin = ci; in_valid = 1'b1; out_ready = early_ready;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("handshake_wait", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (in_ready) begin chk("in_ready_busy", 32'd1, 32'd0); end
      tick(); lat++;
    end
    chk("latency", lat, NCHUNK + 1);
    chk("sum", {12'd0, out_sum}, {12'd0, exp_sum});
    chk("cout", {31'd0, out_cout}, {31'd0, exp_cout});
    if (!early_ready) begin
      held = out_sum;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_sum", {12'd0, out_sum}, {12'd0, held});
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_idle", {31'd0, in_ready}, 32'd1);
    chk("release_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [W:0] full;
    logic [W-1:0] ra, rb;
    logic rc;
    int n;
    int seen;

    vecs[0] = '{20'h00001, 20'h00001, 1'b0, 20'h00002, 1'b0, 0};
    vecs[1] = '{20'hFFFFF, 20'h00000, 1'b1, 20'h00000, 1'b1, 1};
    vecs[2] = '{20'h0001F, 20'h00001, 1'b0, 20'h00020, 1'b0, 0};
    vecs[3] = '{20'h12345, 20'h0ABCD, 1'b0, 20'h1CF12, 1'b0, 6};
    vecs[4] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1, 2};
    vecs[5] = '{20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 0};
    vecs[6] = '{20'h00000, 20'h00000, 1'b1, 20'h00001, 1'b0, 3};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {12'd0, out_sum}, 32'd0);
    chk("rst_cout", {31'd0, out_cout}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].hold, 1'b0);

    // Reset in the second RUN cycle aborts the operation.
    in_a = 20'h55555; in_b = 20'h2AAAA; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_in_ready_rst", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_idle", {31'd0, in_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum", {12'd0, out_sum}, 32'd0);
    chk("abort_cout", {31'd0, out_cout}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid) seen++; end
    chk("abort_no_valid", seen, 0);
    do_op(20'h00003, 20'h00004, 1'b0, 20'h00007, 1'b0, 0, 1'b0);

    // Reset wins over a simultaneous handshake.
    in_a = 20'h00011; in_b = 20'h00022; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_vs_hs_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rst_vs_hs_busy2", {31'd0, busy}, 32'd0);

    // in_valid held high with new operands during RUN/DONE is ignored.
    in_a = 20'h00100; in_b = 20'h00200; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_a = 20'h0F0F0; in_b = 20'h01010; in_cin = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      if (in_ready) begin chk("held_valid_in_ready", 32'd1, 32'd0); end
      tick(); n++;
    end
    chk("held_first_sum", {12'd0, out_sum}, 32'h00300);
    chk("held_first_cout", {31'd0, out_cout}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("held_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("held_second_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("held_second_sum", {12'd0, out_sum}, 32'h10101);
    chk("held_second_cout", {31'd0, out_cout}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Random operations against a plain arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_op(ra, rb, rc, full[W-1:0], full[W], $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
